// File: rtl/dm_cache_responder.sv
`timescale 1ns/1ps
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache responder.
// Read hits complete combinationally; misses and writes stall until the backing memory acks.
module dm_cache_responder #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 15 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [15:0]         rdata_q, rdata_d;
   logic                hit_q, hit_d;
   logic [LINES-1:0]    valid_q, valid_d;

   logic [15:0]         data_q [LINES];
   logic [TAG_BITS-1:0] tag_q  [LINES];

   logic                line_we;
   logic                tag_we;
   logic [15:0]         line_wdata;

   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] lat_idx;
   logic                  lookup_hit;
   logic                  unused_createdump;

   assign unused_createdump = createdump;

   assign req_idx    = Addr[INDEX_BITS:1];
   assign req_tag    = Addr[15:INDEX_BITS+1];
   assign lat_idx    = addr_q[INDEX_BITS:1];
   assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      hit_d      = hit_q;
      valid_d    = valid_q;
      line_we    = 1'b0;
      tag_we     = 1'b0;
      line_wdata = mem_rdata;
      DataOut    = 16'h0000;
      Done       = 1'b0;
      Stall      = 1'b0;
      CacheHit   = 1'b0;
      err        = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;

      // Outputs are forced low while reset is asserted, including the IDLE decode.
      if (rst) begin
         case (state_q)
            IDLE: begin
               err = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
               if (!err && Rd) begin
                  if (lookup_hit) begin
                     Done     = 1'b1;
                     CacheHit = 1'b1;
                     DataOut  = data_q[req_idx];
                  end else begin
                     Stall   = 1'b1;
                     addr_d  = Addr;
                     state_d = RD_WAIT;
                  end
               end else if (!err && Wr) begin
                  Stall   = 1'b1;
                  addr_d  = Addr;
                  wdata_d = DataIn;
                  hit_d   = lookup_hit;
                  state_d = WR_WAIT;
               end
            end
            RD_WAIT: begin
               mem_rd   = 1'b1;
               mem_addr = addr_q;
               Stall    = 1'b1;
               if (mem_ack) begin
                  line_we          = 1'b1;
                  tag_we           = 1'b1;
                  line_wdata       = mem_rdata;
                  valid_d[lat_idx] = 1'b1;
                  rdata_d          = mem_rdata;
                  hit_d            = 1'b0;
                  state_d          = RESP;
               end
            end
            WR_WAIT: begin
               mem_wr    = 1'b1;
               mem_addr  = addr_q;
               mem_wdata = wdata_q;
               Stall     = 1'b1;
               if (mem_ack) begin
                  // Write-through only refreshes a line that already holds this address.
                  line_we    = hit_q;
                  line_wdata = wdata_q;
                  rdata_d    = 16'h0000;
                  state_d    = RESP;
               end
            end
            RESP: begin
               Done     = 1'b1;
               CacheHit = hit_q;
               DataOut  = rdata_q;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         hit_q   <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
         valid_q <= valid_d;
      end
   end

   // Data and tag storage carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (line_we) begin
         data_q[lat_idx] <= line_wdata;
      end
      if (tag_we) begin
         tag_q[lat_idx] <= addr_q[15:INDEX_BITS+1];
      end
   end

endmodule

// File: tb/tb_dm_cache_responder.sv
`timescale 1ns/1ps
// Randomized bench for dm_cache_responder against a line-array cache model plus a backing-memory map.
module tb_dm_cache_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Addr, DataIn;
   logic        Rd, Wr, createdump;
   logic [15:0] DataOut;
   logic        Done, Stall, CacheHit, err;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   dm_cache_responder #(.INDEX_BITS(6)) dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
      .CacheHit(CacheHit), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   bit          m_valid [64];
   logic [8:0]  m_tag   [64];
   logic [15:0] m_data  [64];
   logic [15:0] bmem    [logic [15:0]];

   logic [15:0] g_data;
   logic        g_hit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] bm_rd(input logic [15:0] a);
      if (!bmem.exists(a)) bmem[a] = 16'($urandom);
      return bmem[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // One complete legal transaction; expectations come from the model before it is updated.
   task automatic txn(input bit is_wr, input logic [15:0] a, input logic [15:0] d, input int dly,
                      output logic [15:0] got, output logic got_hit);
      int          idx;
      int          stall_n;
      logic        exp_hit;
      logic [15:0] exp_rd;
      idx     = int'(a[6:1]);
      exp_hit = m_valid[idx] && (m_tag[idx] == a[15:7]);
      exp_rd  = is_wr ? 16'h0000 : (exp_hit ? m_data[idx] : bm_rd(a));
      stall_n = 0;
      @(negedge clk);
      Rd = !is_wr; Wr = is_wr; Addr = a; DataIn = d;
      #1;
      check("req_err", err, 0);
      if (!is_wr && exp_hit) begin
         check("hit_done", Done, 1);
         check("hit_stall", Stall, 0);
         check("hit_memrd", mem_rd, 0);
      end else begin
         check("req_done", Done, 0);
         stall_n += int'(Stall);
         for (int c = 1; c <= dly; c++) begin
            @(negedge clk);
            Addr      = 16'($urandom);
            DataIn    = 16'($urandom);
            mem_ack   = (c == dly);
            mem_rdata = (c == dly && !is_wr) ? exp_rd : 16'($urandom);
            #1;
            stall_n += int'(Stall);
            check("wait_done", Done, 0);
            check("wait_rd", mem_rd, !is_wr);
            check("wait_wr", mem_wr, is_wr);
            check("wait_addr", mem_addr, a);
            check("wait_wdata", mem_wdata, is_wr ? d : 16'h0000);
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 16'($urandom);
         #1;
         check("stall_len", stall_n, dly + 1);
         check("resp_done", Done, 1);
         check("resp_stall", Stall, 0);
         check("resp_mem", {mem_rd, mem_wr}, 0);
      end
      check("hit_flag", CacheHit, exp_hit);
      check("dataout", DataOut, exp_rd);
      got     = DataOut;
      got_hit = CacheHit;
      if (is_wr) begin
         bmem[a] = d;
         if (exp_hit) m_data[idx] = d;
      end else if (!exp_hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = a[15:7];
         m_data[idx]  = exp_rd;
      end
      Rd = 1'b0; Wr = 1'b0;
   endtask

   task automatic err_req(input bit rd, input bit wr, input logic [15:0] a);
      @(negedge clk);
      Rd = rd; Wr = wr; Addr = a;
      #1;
      check("err_flag", err, 1);
      check("err_done", Done, 0);
      check("err_stall", Stall, 0);
      check("err_mem", {mem_rd, mem_wr}, 0);
      check("err_dout", DataOut, 0);
      Rd = 1'b0; Wr = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      rst = 1'b0; Rd = 1'b1; Wr = 1'b1; Addr = 16'h0001; DataIn = 16'h0000;
      createdump = 1'b0; mem_rdata = 16'h0000; mem_ack = 1'b0;
      clear_model();
      #2;
      check("rst_done", Done, 0);
      check("rst_stall", Stall, 0);
      check("rst_err", err, 0);
      check("rst_mem", {mem_rd, mem_wr}, 0);
      check("rst_dout", DataOut, 0);
      check("rst_hit", CacheHit, 0);
      @(negedge clk);
      Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000;
      rst = 1'b1;

      // Directed scenarios
      bmem[16'h0010] = 16'hBEEF;
      txn(0, 16'h0010, 16'h0000, 3, g_data, g_hit);
      check("plan_fill_data", g_data, 16'hBEEF);
      check("plan_fill_hit", g_hit, 0);
      txn(0, 16'h0010, 16'h0000, 1, g_data, g_hit);
      check("plan_rehit", g_hit, 1);
      txn(1, 16'h0010, 16'h1234, 2, g_data, g_hit);
      check("plan_wr_hit", g_hit, 1);
      txn(0, 16'h0010, 16'h0000, 1, g_data, g_hit);
      check("plan_wr_rd", g_data, 16'h1234);
      txn(1, 16'h0080, 16'h5555, 2, g_data, g_hit);
      check("plan_wr_miss", g_hit, 0);
      txn(0, 16'h0080, 16'h0000, 2, g_data, g_hit);
      check("plan_no_alloc", g_hit, 0);
      check("plan_no_alloc_d", g_data, 16'h5555);
      txn(0, 16'h0090, 16'h0000, 2, g_data, g_hit);
      check("plan_conflict", g_hit, 0);
      txn(0, 16'h0010, 16'h0000, 1, g_data, g_hit);
      check("plan_evicted", g_hit, 0);
      err_req(1, 1, 16'h0010);
      err_req(1, 0, 16'h0011);
      err_req(0, 1, 16'h0013);
      txn(0, 16'h0010, 16'h0000, 1, g_data, g_hit);
      check("plan_err_nochg", g_hit, 1);

      // Reset while a refill is outstanding
      @(negedge clk);
      Rd = 1'b1; Addr = 16'h0220;
      #1;
      check("rstop_stall", Stall, 1);
      @(negedge clk);
      #1;
      check("rstop_memrd", mem_rd, 1);
      #1 rst = 1'b0;
      #1;
      check("rstop_drop", mem_rd, 0);
      check("rstop_stall0", Stall, 0);
      Rd = 1'b0;
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check("stray_done", Done, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("stray_done2", Done, 0);
      check("stray_stall", Stall, 0);
      txn(0, 16'h0010, 16'h0000, 2, g_data, g_hit);
      check("rst_inval", g_hit, 0);

      // Randomized traffic over a small address pool to force hits and conflicts
      for (int n = 0; n < 300; n++) begin
         a = (16'($urandom_range(0, 3)) << 7) | (16'($urandom_range(0, 7)) << 1);
         case ($urandom_range(0, 9))
            0: begin
               if ($urandom_range(0, 1) == 0) err_req(1, 1, a);
               else err_req(1'($urandom_range(0, 1)), 1'b1, a | 16'h0001);
            end
            1: begin
               @(negedge clk);
               Rd = 1'b0; Wr = 1'b0;
               #1;
               check("idle_done", Done, 0);
               check("idle_stall", Stall, 0);
               check("idle_err", err, 0);
            end
            2, 3, 4: txn(1, a, 16'($urandom), int'($urandom_range(1, 4)), g_data, g_hit);
            default: txn(0, a, 16'h0000, int'($urandom_range(1, 4)), g_data, g_hit);
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
